// File: rtl/multiplex_pipe_if.sv
// Handshake bundle for multiplex_pipe: upstream select/data beat,
// downstream result beat and the selection-error counter.
interface multiplex_pipe_if #(
  parameter int DATA_SIZE     = 32,
  parameter int NUM_INPUTS    = 4,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int SEL_WIDTH     =
    (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
);
  logic [SEL_WIDTH-1:0]            selection_in;
  logic [NUM_INPUTS*DATA_SIZE-1:0] data_in;
  logic                            valid_in;
  logic                            ready_out;
  logic [DATA_SIZE-1:0]            data_out;
  logic                            sel_error_out;
  logic                            valid_out;
  logic                            ready_in;
  logic                            error_clear_in;
  logic [ERR_CNT_WIDTH-1:0]        error_count_out;

  modport master (
    output selection_in, data_in, valid_in,
    output ready_in, error_clear_in,
    input  ready_out, data_out, sel_error_out,
    input  valid_out, error_count_out
  );

  modport slave (
    input  selection_in, data_in, valid_in,
    input  ready_in, error_clear_in,
    output ready_out, data_out, sel_error_out,
    output valid_out, error_count_out
  );
endinterface

// File: rtl/multiplex_pipe.sv
// N-way registered selector with a 2-entry output/skid buffer
// and a saturating out-of-range selection counter.
module multiplex_pipe #(
  parameter int DATA_SIZE     = 32,
  parameter int NUM_INPUTS    = 4,
  parameter int DEFAULT_VALUE = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input logic             clock_in,
  input logic             reset_in,
  multiplex_pipe_if.slave bus
);
  localparam int SEL_WIDTH =
    (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [DATA_SIZE-1:0] DEF_WORD =
    DATA_SIZE'(DEFAULT_VALUE);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                   state;
  logic                     ready_q;
  logic                     valid_q;
  logic [DATA_SIZE-1:0]     out_data;
  logic                     out_err;
  logic [DATA_SIZE-1:0]     skid_data;
  logic                     skid_err;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  logic                     accept;
  logic                     emit;
  logic [DATA_SIZE-1:0]     sel_data;
  logic                     sel_err;
  logic [SEL_WIDTH-1:0]     sel;

  assign sel    = bus.selection_in;
  assign accept = bus.valid_in && ready_q;
  assign emit   = valid_q && bus.ready_in;

  always_comb begin
    sel_data = DEF_WORD;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        sel_data = bus.data_in[k*DATA_SIZE +: DATA_SIZE];
        sel_err  = 1'b0;
      end
    end
  end

  // ready_q tracks the next state so it is low exactly in TWO
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state     <= EMPTY;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_data <= sel_data;
            out_err  <= sel_err;
            valid_q  <= 1'b1;
            state    <= ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept && emit: begin
              out_data <= sel_data;
              out_err  <= sel_err;
            end
            accept && !emit: begin
              skid_data <= sel_data;
              skid_err  <= sel_err;
              ready_q   <= 1'b0;
              state     <= TWO;
            end
            !accept && emit: begin
              valid_q <= 1'b0;
              state   <= EMPTY;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (emit) begin
            out_data <= skid_data;
            out_err  <= skid_err;
            ready_q  <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // clear wins over a same-cycle error beat
  always_ff @(posedge clock_in) begin
    if (reset_in || bus.error_clear_in) begin
      err_cnt <= '0;
    end else if (accept && sel_err && err_cnt != ERR_MAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.ready_out       = ready_q;
  assign bus.valid_out       = valid_q;
  assign bus.data_out        = out_data;
  assign bus.sel_error_out   = out_err;
  assign bus.error_count_out = err_cnt;
endmodule

// File: tb/tb_multiplex_pipe.sv
// Directed bench for multiplex_pipe: 3 inputs, 32-bit words,
// default word 1, 8-bit error counter.
module tb_multiplex_pipe;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  multiplex_pipe_if #(
    .DATA_SIZE(32), .NUM_INPUTS(3), .ERR_CNT_WIDTH(8)
  ) bus ();

  multiplex_pipe #(
    .DATA_SIZE(32), .NUM_INPUTS(3),
    .DEFAULT_VALUE(1), .ERR_CNT_WIDTH(8)
  ) dut (
    .clock_in(clk),
    .reset_in(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst ready_out", 32'(bus.ready_out), 32'd1);
    chk("rst count", 32'(bus.error_count_out), 32'd0);
    chk("rst data_out", bus.data_out, 32'd0);
    step();
    chk("idle valid_out", 32'(bus.valid_out), 32'd0);
    chk("idle ready_out", 32'(bus.ready_out), 32'd1);
  endtask

  task automatic test_select();
    bus.data_in  = {32'hC, 32'hB, 32'hA};
    bus.ready_in = 1'b1;
    bus.selection_in = 2'd2;
    bus.valid_in = 1'b1;
    step();
    chk("sel2 data", bus.data_out, 32'hC);
    chk("sel2 valid", 32'(bus.valid_out), 32'd1);
    chk("sel2 err", 32'(bus.sel_error_out), 32'd0);
    bus.selection_in = 2'd0;
    step();
    chk("sel0 data", bus.data_out, 32'hA);
    bus.selection_in = 2'd1;
    step();
    chk("sel1 data", bus.data_out, 32'hB);
    chk("sel1 err", 32'(bus.sel_error_out), 32'd0);
    bus.valid_in = 1'b0;
    step();
    chk("drain valid", 32'(bus.valid_out), 32'd0);
  endtask

  task automatic test_error();
    bus.selection_in = 2'd3;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    chk("oor data", bus.data_out, 32'h1);
    chk("oor err", 32'(bus.sel_error_out), 32'd1);
    chk("oor count", 32'(bus.error_count_out), 32'd1);
    step();
    chk("oor drain", 32'(bus.valid_out), 32'd0);
    chk("count hold", 32'(bus.error_count_out), 32'd1);
  endtask

  task automatic test_back_to_back();
    bus.ready_in = 1'b0;
    bus.selection_in = 2'd0;
    bus.valid_in = 1'b1;
    bus.data_in = {32'hC, 32'hB, 32'h11};
    step();
    chk("b2b first", bus.data_out, 32'h11);
    chk("b2b rdy1", 32'(bus.ready_out), 32'd1);
    bus.data_in = {32'hC, 32'hB, 32'h22};
    step();
    chk("b2b full rdy", 32'(bus.ready_out), 32'd0);
    bus.data_in = {32'hC, 32'hB, 32'h33};
    step();
    chk("b2b hold data", bus.data_out, 32'h11);
    chk("b2b hold rdy", 32'(bus.ready_out), 32'd0);
    chk("b2b hold valid", 32'(bus.valid_out), 32'd1);
    bus.ready_in = 1'b1;
    step();
    chk("b2b out2", bus.data_out, 32'h22);
    chk("b2b rdy back", 32'(bus.ready_out), 32'd1);
    step();
    bus.valid_in = 1'b0;
    chk("b2b out3", bus.data_out, 32'h33);
    chk("b2b out3 valid", 32'(bus.valid_out), 32'd1);
    step();
    chk("b2b drained", 32'(bus.valid_out), 32'd0);
  endtask

  task automatic test_saturation();
    bus.error_clear_in = 1'b1;
    step();
    bus.error_clear_in = 1'b0;
    chk("clear", 32'(bus.error_count_out), 32'd0);
    bus.ready_in = 1'b1;
    bus.selection_in = 2'd3;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 255; i++) step();
    chk("cnt 255", 32'(bus.error_count_out), 32'd255);
    step();
    chk("cnt sat", 32'(bus.error_count_out), 32'd255);
    bus.error_clear_in = 1'b1;
    step();
    bus.error_clear_in = 1'b0;
    chk("clear prio", 32'(bus.error_count_out), 32'd0);
    bus.valid_in = 1'b0;
    step();
    chk("after clr", 32'(bus.error_count_out), 32'd0);
  endtask

  task automatic test_reset_in_two();
    bus.ready_in = 1'b0;
    bus.selection_in = 2'd0;
    bus.valid_in = 1'b1;
    bus.data_in = {32'hC, 32'hB, 32'h44};
    step();
    bus.data_in = {32'hC, 32'hB, 32'h55};
    step();
    chk("two rdy", 32'(bus.ready_out), 32'd0);
    bus.valid_in = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst valid", 32'(bus.valid_out), 32'd0);
    chk("mid rst ready", 32'(bus.ready_out), 32'd1);
    chk("mid rst data", bus.data_out, 32'd0);
    bus.ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no ghost beat", 32'(bus.valid_out), 32'd0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    bus.selection_in = '0;
    bus.data_in = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.error_clear_in = 1'b0;
    test_reset();
    test_select();
    test_error();
    test_back_to_back();
    test_saturation();
    test_reset_in_two();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
